// File: rtl/char_ram_reader.sv
// Streams a captured character window out of a 1-cycle-latency RAM in raster order over valid/ready.
// Optional read-and-clear mode (zero each pixel after it is sent) is enabled by defining CHAR_READ_CLEAR_EN.
module char_ram_reader #(
  parameter int CHAR_W = 200,
  parameter int CHAR_H = 105,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_col,
  output logic [6:0]        pix_row,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
`ifdef CHAR_READ_CLEAR_EN
  ,
  output logic              ram_clr_we,
  output logic [ADDR_W-1:0] ram_clr_addr
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHAR_W * CHAR_H - 1);
  localparam logic [7:0]        LAST_COL  = 8'(CHAR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic       eof;
    logic [7:0] col;
    logic [6:0] row;
  } tag_t;

  typedef struct packed {
    tag_t              tag;
    logic [DATA_W-1:0] data;
  } pix_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        col_q, col_d;
  logic [6:0]        row_q, row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              infl_vld_q, infl_vld_d;
  tag_t              infl_tag_q, infl_tag_d;
  logic              out_vld_q, out_vld_d;
  pix_t              out_q, out_d;
  logic              skid_vld_q, skid_vld_d;
  pix_t              skid_q, skid_d;

  logic              xfer_s;
  logic [1:0]        occ_s;
  logic              issue_s;
  tag_t              iss_tag_s;
  pix_t              arr_s;

  // Handshake, slot accounting and the tag of the address being presented.
  always_comb begin
    xfer_s  = out_vld_q & pix_ready;
    // Slots committed after this edge; an issue now lands one cycle later and must still fit.
    occ_s   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, infl_vld_q} - {1'b0, xfer_s};
    issue_s = (state_q == S_ISSUE) && (occ_s < 2'd2);

    iss_tag_s.sof = (addr_q == '0);
    iss_tag_s.eol = (col_q == LAST_COL);
    iss_tag_s.eof = (addr_q == LAST_ADDR);
    iss_tag_s.col = col_q;
    iss_tag_s.row = row_q;

    arr_s.tag  = infl_tag_q;
    arr_s.data = ram_rd_data;
  end

  // Frame sequencing and read-address / row-column generation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (issue_s) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == LAST_COL) begin
              col_d = 8'd0;
              row_d = row_q + 7'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (xfer_s && out_q.tag.eof) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
        col_d   = 8'd0;
        row_d   = 7'd0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        col_d   = 8'd0;
        row_d   = 7'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output register plus skid register; the skid entry is always older than RAM return data.
  always_comb begin
    infl_vld_d = issue_s;
    infl_tag_d = issue_s ? iss_tag_s : '0;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (!out_vld_q || xfer_s) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_d      = skid_q;
        skid_vld_d = infl_vld_q;
        skid_d     = infl_vld_q ? arr_s : '0;
      end else if (infl_vld_q) begin
        out_vld_d = 1'b1;
        out_d     = arr_s;
      end else begin
        out_vld_d = 1'b0;
        out_d     = '0;
      end
    end else begin
      if (infl_vld_q) begin
        skid_vld_d = 1'b1;
        skid_d     = arr_s;
      end else begin
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      col_q      <= 8'd0;
      row_q      <= 7'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      infl_vld_q <= 1'b0;
      infl_tag_q <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      infl_vld_q <= infl_vld_d;
      infl_tag_q <= infl_tag_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_rd_addr = addr_q;
  assign pix_valid   = out_vld_q;
  assign pix_data    = out_q.data;
  assign pix_col     = out_q.tag.col;
  assign pix_row     = out_q.tag.row;
  assign pix_sof     = out_q.tag.sof;
  assign pix_eol     = out_q.tag.eol;
  assign pix_eof     = out_q.tag.eof;

`ifdef CHAR_READ_CLEAR_EN
  logic              clr_we_q, clr_we_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] xfer_cnt_q, xfer_cnt_d;

  // Pixels leave strictly in address order, so a transfer counter is the address to clear.
  always_comb begin
    clr_we_d   = xfer_s;
    clr_addr_d = clr_addr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (xfer_s) begin
      clr_addr_d = xfer_cnt_q;
      xfer_cnt_d = xfer_cnt_q + ADDR_W'(1);
    end else if (state_q == S_IDLE) begin
      xfer_cnt_d = '0;
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  // Clear-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_we_q   <= 1'b0;
      clr_addr_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      clr_we_q   <= clr_we_d;
      clr_addr_q <= clr_addr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign ram_clr_we   = clr_we_q;
  assign ram_clr_addr = clr_addr_q;
`endif

endmodule

// File: tb/tb_char_ram_reader.sv
// Self-checking bench for char_ram_reader: raster-order model plus directed latency/stall/restart/reset cases.
// Covers the CHAR_READ_CLEAR_EN build as well when that macro is defined.
module tb_char_ram_reader;
  localparam int CHAR_W = 200;
  localparam int CHAR_H = 105;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int NPIX   = CHAR_W * CHAR_H;

  logic              clk = 1'b0;
  logic              rst_n, start, pix_ready;
  logic              busy, done, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data, pix_data;
  logic [7:0]        pix_col;
  logic [6:0]        pix_row;
`ifdef CHAR_READ_CLEAR_EN
  logic              ram_clr_we;
  logic [ADDR_W-1:0] ram_clr_addr;
  int                clr_cnt = 0;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  logic ram_load;
  logic model_zero;
  logic [7:0] ram [0:(1<<ADDR_W)-1];

  // Model state, owned by the compare process.
  int          k = 0;
  int          prev_k = 0;
  logic        m_busy = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_eofx = 1'b0;
  logic        prev_xfer = 1'b0;
  logic [26:0] held = '0;

  always #5 clk = ~clk;

  char_ram_reader #(.CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_col(pix_col), .pix_row(pix_row),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
`ifdef CHAR_READ_CLEAR_EN
    , .ram_clr_we(ram_clr_we), .ram_clr_addr(ram_clr_addr)
`endif
  );

  // Synchronous-read RAM preloaded with data = addr[7:0].
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 8'(i);
    end
`ifdef CHAR_READ_CLEAR_EN
    else if (ram_clr_we) ram[ram_clr_addr] <= 8'h00;
`endif
    ram_rd_data <= ram[ram_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the raster-order model.
  always @(negedge clk) begin
    logic        xf;
    logic        in_done;
    logic [26:0] cur;
    if (!rst_n) begin
      check("rst_outputs", {3'b0, busy, done, pix_valid, pix_sof, pix_eol, pix_eof,
                            pix_data, pix_col, pix_row}, 32'd0);
      check("rst_addr", 32'(ram_rd_addr), 32'd0);
      m_busy = 1'b0; k = 0; prev_stall = 1'b0; prev_eofx = 1'b0; prev_xfer = 1'b0;
    end else begin
      in_done = prev_eofx;
      check("done", 32'(done), 32'(in_done));
      check("busy", 32'(busy), 32'(m_busy));
      if (done) check("frame_len", k, NPIX);
      if (!pix_valid) check("tag_gate", {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
      cur = {pix_valid, pix_data, pix_col, pix_row, pix_sof, pix_eol, pix_eof};
      if (prev_stall) check("hold", 32'(cur), 32'(held));
      if (m_busy) check("addr_lead", 32'(32'(ram_rd_addr) <= k + 2), 32'd1);
`ifdef CHAR_READ_CLEAR_EN
      check("clr_we", 32'(ram_clr_we), 32'(prev_xfer));
      if (prev_xfer) check("clr_addr", 32'(ram_clr_addr), prev_k);
      if (ram_clr_we) clr_cnt++;
`endif
      xf = pix_valid && pix_ready;
      if (xf) begin
        check("pix_index", 32'(k < NPIX), 32'd1);
        check("pix_data", 32'(pix_data), model_zero ? 32'd0 : k % 256);
        check("pix_col", 32'(pix_col), k % CHAR_W);
        check("pix_row", 32'(pix_row), k / CHAR_W);
        check("pix_flags", {29'd0, pix_sof, pix_eol, pix_eof},
              {29'd0, k == 0, (k % CHAR_W) == CHAR_W - 1, k == NPIX - 1});
      end
      prev_stall = pix_valid && !pix_ready;
      held       = cur;
      prev_xfer  = xf;
      prev_k     = k;
      prev_eofx  = xf && (k == NPIX - 1);
      if (xf) k++;
      if (prev_eofx) m_busy = 1'b0;
      else if (start && !m_busy && !in_done) begin
        m_busy = 1'b1;
        k = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_k(input int target, input int budget);
    int n = 0;
    while (k != target && n < budget) begin
      cyc();
      n++;
    end
    if (k != target) check("timeout_k", k, target);
  endtask

  task automatic wait_done(input bit rnd, input int budget, input logic [7:0] last_data);
    int n = 0;
    bit seen = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      if (pix_valid && pix_ready && pix_eof) begin
        check("last_data", 32'(pix_data), 32'(last_data));
        check("last_col", 32'(pix_col), 32'd199);
        check("last_row", 32'(pix_row), 32'd104);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc();
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_first_pixel(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 32'd1);
    check({tag, "_data"}, 32'(pix_data), 32'd0);
    check({tag, "_pos"}, {17'd0, pix_col, pix_row}, 32'd0);
    check({tag, "_sof"}, 32'(pix_sof), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1; ram_load = 1'b1; model_zero = 1'b0;
    cyc();
    ram_load = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Frame A: latency, stall at pixel 350, start ignored mid-frame.
    pulse_start();
    check("lat_addr0", 32'(ram_rd_addr), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_valid_e0", 32'(pix_valid), 32'd0);
    cyc();
    check("lat_valid_e1", 32'(pix_valid), 32'd0);
    cyc();
    check_first_pixel("a_first");

    wait_k(350, 1000);
    pix_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("stall_data", 32'(pix_data), 32'd94);
      check("stall_col", 32'(pix_col), 32'd150);
      check("stall_row", 32'(pix_row), 32'd1);
      check("stall_addr", 32'(32'(ram_rd_addr) <= 352), 32'd1);
      cyc();
    end
    pix_ready = 1'b1;
    @(negedge clk);
    check("resume_col", 32'(pix_col), 32'd150);
    @(negedge clk);
    check("resume_next_col", 32'(pix_col), 32'd151);
    check("resume_next_data", 32'(pix_data), 32'd95);
    cyc();

    wait_k(5000, 10000);
    pulse_start();
    check("busy_after_restart_req", 32'(busy), 32'd1);
    wait_done(1'b0, 20000, 8'd7);
    cyc();
`ifdef CHAR_READ_CLEAR_EN
    check("clr_count", clr_cnt, NPIX);
    model_zero = 1'b1;
`endif

    // Frame B: fresh start from IDLE, random backpressure.
    repeat (3) cyc();
    check("idle_addr", 32'(ram_rd_addr), 32'd0);
    pulse_start();
    check("b_addr0", 32'(ram_rd_addr), 32'd0);
    wait_done(1'b1, 60000, model_zero ? 8'd0 : 8'd7);
    pix_ready = 1'b1;

    // Frame C: asynchronous reset mid-frame, then restart.
    repeat (2) cyc();
    pulse_start();
    wait_k(12000, 20000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", {3'b0, busy, done, pix_valid, pix_sof, pix_eol, pix_eof,
                           pix_data, pix_col, pix_row}, 32'd0);
    check("arst_addr", 32'(ram_rd_addr), 32'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    pulse_start();
    cyc(); cyc();
    check_first_pixel("restart");
    wait_k(500, 2000);
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_ram_reader.md
Name: char_ram_reader

Overview:
- Read-side counterpart of the character-capture address writer.
- After a capture completes, this block walks the character RAM in raster order and streams pixels to the recognition datapath over a valid/ready interface.
- Outputs carry row/column tags and frame markers.
- Hides the RAM's 1-cycle synchronous read latency behind a 2-entry skid buffer so backpressure never drops or duplicates a pixel.

Parameters:
- CHAR_W, 200, character window width in pixels
- CHAR_H, 105, character window height in lines
- ADDR_W, 15, RAM address width; CHAR_W*CHAR_H must be <= 2**ADDR_W
- DATA_W, 8, RAM word / pixel width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to read one full character frame
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after last pixel handshake
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data, valid 1 cycle after address
- pix_data  out  DATA_W  pixel value
- pix_valid  out  1  pixel valid
- pix_ready  in  1  downstream ready
- pix_col  out  8  column 0..CHAR_W-1
- pix_row  out  7  row 0..CHAR_H-1
- pix_sof  out  1  first pixel of frame (row 0, col 0)
- pix_eol  out  1  last pixel of a row (col CHAR_W-1)
- pix_eof  out  1  last pixel of frame

Behaviour:
- Reset: all outputs 0, state IDLE, read address counter 0, skid buffer empty. Applies immediately on rst_n low, also mid-frame; in-flight RAM data is discarded.
- Transfer: occurs on any edge with pix_valid && pix_ready.
- States:
  - IDLE: wait for start.
  - ISSUE: present addresses.
  - DRAIN: all addresses issued, buffer not empty.
  - DONE: one cycle, done=1, then IDLE.
- IDLE -> ISSUE on start; busy rises on the same edge.
- start while busy is ignored.
- ISSUE -> DRAIN once address CHAR_W*CHAR_H-1 (20999 by default) has been issued.
- DRAIN -> DONE on the edge of the final transfer.
- Issue rule: a new address is issued in a cycle only if (buffered entries + in-flight read) < 2, counting a transfer in that same cycle as freeing a slot.
  - ram_rd_addr holds its value when not issuing.
  - ram_rd_addr returns to 0 in IDLE.
- Returned data enters the output register if it is free or transferring, otherwise the skid register.
  - Order is preserved.
  - Each pixel carries its own address-derived row/col/sof/eol/eof tags.
- Latency: start sampled at edge E0 -> ram_rd_addr=0 after E0 -> pix_valid=1 with pixel 0 after E2.
- Throughput: with pix_ready held high, one pixel per cycle; the full frame takes 21000 transfer cycles plus 2 cycles latency.
- Stability: while pix_valid && !pix_ready, pix_data and all tags are held stable.
- Tags:
  - col/row counters wrap col CHAR_W-1 -> 0 with row+1.
  - sof, eol, eof are asserted only together with pix_valid.
  - eof implies eol.
- done is asserted the cycle after the eof transfer; busy falls with done.

Optional Feature:
- CHAR_READ_CLEAR_EN: read-and-clear mode, so the RAM is blank for the next capture without a separate clear pass.
- With the macro defined:
  - Adds ports ram_clr_we (out, 1) and ram_clr_addr (out, ADDR_W).
  - On each pixel transfer, the next cycle drives ram_clr_we=1 with ram_clr_addr = that pixel's address, writing zero.
  - Both outputs reset to 0.
- Without the macro: these ports and the logic behind them do not exist; RAM contents are untouched.

Test Plan:
- RAM preloaded data=addr[7:0], pix_ready=1, start pulse -> pix_valid 2 cycles after start. 21000 transfers with data matching the address pattern. sof only on the first (row0,col0). eol on every col 199. eof on row104,col199. done pulse the cycle after, busy low.
- pix_ready random at 50% -> exactly 21000 transfers, in order, no duplicates or gaps; ram_rd_addr never more than 2 ahead of the transferred pixel index.
- pix_ready low for 10 cycles at pixel 350 (row1,col150) -> pix_data/col/row held; ram_rd_addr stalls at <=352; resume with pixel 351 next.
- start pulsed again at pixel 5000 -> ignored, frame continues. start pulsed in IDLE after done -> fresh frame from address 0.
- rst_n low at pixel 12000 -> all outputs 0 asynchronously. After release and start, stream restarts at row0,col0 with correct data.
- With CHAR_READ_CLEAR_EN, full frame -> ram_clr_we pulses 21000 times, addresses 0..20999 in order; a second read returns all zeros.
